// File: rtl/xalu_seq.sv
// xalu_seq: sequenced signed ALU with ADD/SUB (single cycle), MUL (shift-add)
// and optional DIV (restoring), both iterative over W cycles on magnitudes.
// Optional feature macro: ALU_DIV_EN -- when defined, the divider datapath is
// built; when undefined, opcode 3 is reported as illegal.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | out of reset, nothing computed yet, accepts a start
// RUN   | operation in progress, cnt counts remaining iterations
// FIN   | results/flags valid and held, accepts a back-to-back start
module xalu_seq #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         alu_sel,
   input  logic         wr_enable,
   input  logic [W-1:0] first_nr,
   input  logic [W-1:0] second_nr,
   input  logic [3:0]   operation,
   output logic [W-1:0] result_lo,
   output logic [W-1:0] result_hi,
   output logic         busy,
   output logic         alu_done,
   output logic         ovf,
   output logic         err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
`ifdef ALU_DIV_EN
   localparam logic [3:0] OP_DIV = 4'd3;
`endif

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_ITER = CW'(W);

   logic [1:0]     state;
   logic [3:0]     op_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   mag_b;
   // MUL: {partial product high, multiplier shifting out}
   // DIV: {partial remainder, dividend shifting out / quotient shifting in}
   logic [2*W-1:0] prod;
   logic [CW-1:0]  cnt;

   logic           start;
   logic           iter_in;
   logic [W:0]     add_sum;
   logic [2*W-1:0] prod_nx;
   logic [2*W-1:0] mul_p;
   logic [W-1:0]   sum_ab;
   logic [W-1:0]   dif_ab;
   logic [W-1:0]   fin_lo;
   logic [W-1:0]   fin_hi;
   logic           fin_ovf;
   logic           fin_err;
`ifdef ALU_DIV_EN
   logic [W:0]     sub_shift;
   logic [W:0]     sub_diff;
   logic [W-1:0]   quo;
   logic [W-1:0]   rem;
`endif

   function automatic logic [W-1:0] mag_of(input logic [W-1:0] x);
      mag_of = x[W-1] ? ('0 - x) : x;
   endfunction

   assign start = alu_sel & wr_enable & (state != S_RUN);

   // Decide whether the incoming request needs the iterative datapath; a zero
   // divisor skips the iterations and is resolved in the single finish cycle.
   always_comb begin
      iter_in = (operation == OP_MUL);
`ifdef ALU_DIV_EN
      if ((operation == OP_DIV) && (second_nr != '0))
         iter_in = 1'b1;
`endif
   end

   // One iteration step of shift-add multiply or restoring divide.
   always_comb begin
      add_sum = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mag_b} : '0);
      prod_nx = {add_sum, prod[W-1:1]};
`ifdef ALU_DIV_EN
      sub_shift = {prod[2*W-1:W], prod[W-1]};
      sub_diff  = sub_shift - {1'b0, mag_b};
      if (op_q != OP_MUL) begin
         if (sub_diff[W])
            prod_nx = {sub_shift[W-1:0], prod[W-2:0], 1'b0};
         else
            prod_nx = {sub_diff[W-1:0], prod[W-2:0], 1'b1};
      end
`endif
   end

   // Final result and flags, applied on the edge that leaves RUN.
   always_comb begin
      fin_lo  = '0;
      fin_hi  = '0;
      fin_ovf = 1'b0;
      fin_err = 1'b0;
      sum_ab  = a_q + b_q;
      dif_ab  = a_q - b_q;
      mul_p   = (a_q[W-1] ^ b_q[W-1]) ? ('0 - prod) : prod;
`ifdef ALU_DIV_EN
      quo = (a_q[W-1] ^ b_q[W-1]) ? ('0 - prod[W-1:0]) : prod[W-1:0];
      rem = a_q[W-1] ? ('0 - prod[2*W-1:W]) : prod[2*W-1:W];
`endif
      case (op_q)
         OP_ADD: begin
            fin_lo  = sum_ab;
            fin_hi  = {W{sum_ab[W-1]}};
            fin_ovf = (a_q[W-1] == b_q[W-1]) && (sum_ab[W-1] != a_q[W-1]);
         end
         OP_SUB: begin
            fin_lo  = dif_ab;
            fin_hi  = {W{dif_ab[W-1]}};
            fin_ovf = (a_q[W-1] != b_q[W-1]) && (dif_ab[W-1] != a_q[W-1]);
         end
         OP_MUL: begin
            fin_lo = mul_p[W-1:0];
            fin_hi = mul_p[2*W-1:W];
         end
`ifdef ALU_DIV_EN
         OP_DIV: begin
            if (b_q == '0) begin
               fin_err = 1'b1;
               fin_lo  = '1;
               fin_hi  = a_q;
            end else begin
               // most-negative / -1: magnitude quotient 2^(W-1) already reads
               // back as the most-negative pattern, only the flag is extra
               fin_lo  = quo;
               fin_hi  = rem;
               fin_ovf = (a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == '1);
            end
         end
`endif
         default: begin
            fin_err = 1'b1;
         end
      endcase
   end

   // Sequencer: accept starts in IDLE/FIN, iterate in RUN, hold results in FIN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         mag_b     <= '0;
         prod      <= '0;
         cnt       <= '0;
         result_lo <= '0;
         result_hi <= '0;
         busy      <= 1'b0;
         alu_done  <= 1'b0;
         ovf       <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_FIN: begin
               if (start) begin
                  state    <= S_RUN;
                  op_q     <= operation;
                  a_q      <= first_nr;
                  b_q      <= second_nr;
                  mag_b    <= mag_of(second_nr);
                  prod     <= {{W{1'b0}}, mag_of(first_nr)};
                  cnt      <= iter_in ? CNT_ITER : '0;
                  busy     <= 1'b1;
                  alu_done <= 1'b0;
                  ovf      <= 1'b0;
                  err      <= 1'b0;
               end
            end
            S_RUN: begin
               if (cnt != '0) begin
                  prod <= prod_nx;
                  cnt  <= cnt - 1'b1;
               end else begin
                  state     <= S_FIN;
                  result_lo <= fin_lo;
                  result_hi <= fin_hi;
                  ovf       <= fin_ovf;
                  err       <= fin_err;
                  busy      <= 1'b0;
                  alu_done  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xalu_seq.sv
// tb_xalu_seq: directed corner cases plus randomized operations for xalu_seq
// (W = 8), compared against an integer-arithmetic reference model.
module tb_xalu_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       alu_sel = 1'b0;
   logic       wr_enable = 1'b0;
   logic [7:0] first_nr = '0;
   logic [7:0] second_nr = '0;
   logic [3:0] operation = '0;
   logic [7:0] result_lo;
   logic [7:0] result_hi;
   logic       busy;
   logic       alu_done;
   logic       ovf;
   logic       err;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_lo;
   logic [7:0] exp_hi;
   logic       exp_ovf;
   logic       exp_err;
   int         exp_lat;

   xalu_seq #(.W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_sel   (alu_sel),
      .wr_enable (wr_enable),
      .first_nr  (first_nr),
      .second_nr (second_nr),
      .operation (operation),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .busy      (busy),
      .alu_done  (alu_done),
      .ovf       (ovf),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference: plain signed integer arithmetic on the operand values.
   task automatic model(input logic [3:0] op, input int a, input int b);
      int r;
      exp_lo = '0; exp_hi = '0; exp_ovf = 1'b0; exp_err = 1'b0; exp_lat = 1;
      case (op)
         4'd0: begin
            r = a + b; exp_lo = r[7:0]; exp_hi = exp_lo[7] ? 8'hFF : 8'h00;
            exp_ovf = (r > 127) || (r < -128);
         end
         4'd1: begin
            r = a - b; exp_lo = r[7:0]; exp_hi = exp_lo[7] ? 8'hFF : 8'h00;
            exp_ovf = (r > 127) || (r < -128);
         end
         4'd2: begin
            r = a * b; exp_lo = r[7:0]; exp_hi = r[15:8]; exp_lat = 9;
         end
         4'd3: begin
`ifdef ALU_DIV_EN
            if (b == 0) begin
               exp_err = 1'b1; exp_lo = 8'hFF; r = a; exp_hi = r[7:0];
            end else begin
               r = a / b; exp_lo = r[7:0];
               r = a % b; exp_hi = r[7:0];
               exp_ovf = (a == -128) && (b == -1);
               exp_lat = 9;
            end
`else
            exp_err = 1'b1;
`endif
         end
         default: exp_err = 1'b1;
      endcase
   endtask

   task automatic drive_req(input logic [3:0] op, input int a, input int b);
      alu_sel = 1'b1; wr_enable = 1'b1; operation = op;
      first_nr = a[7:0]; second_nr = b[7:0];
   endtask

   task automatic drop_req();
      alu_sel = 1'b0; wr_enable = 1'b0;
   endtask

   task automatic wait_done(input string tag, inout int lat);
      while (!alu_done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_val({tag, "_lat"}, lat, exp_lat);
      check_val({tag, "_lo"}, result_lo, exp_lo);
      check_val({tag, "_hi"}, result_hi, exp_hi);
      check_val({tag, "_ovf"}, ovf, exp_ovf);
      check_val({tag, "_err"}, err, exp_err);
      check_val({tag, "_busy"}, busy, 0);
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input int a, input int b);
      int lat;
      model(op, a, b);
      @(negedge clk);
      drive_req(op, a, b);
      @(posedge clk);
      @(negedge clk);
      drop_req();
      check_val({tag, "_busy_start"}, busy, 1);
      check_val({tag, "_done_clr"}, alu_done, 0);
      lat = 0;
      wait_done(tag, lat);
   endtask

   task automatic check_hold(input string tag);
      repeat (3) @(negedge clk);
      check_val({tag, "_hold_lo"}, result_lo, exp_lo);
      check_val({tag, "_hold_hi"}, result_hi, exp_hi);
      check_val({tag, "_hold_done"}, alu_done, 1);
   endtask

   initial begin
      int lat;
      int seen;
      int a;
      int b;
      int sel;
      logic [3:0] op;

      #12;
      check_val("rst_lo", result_lo, 0);
      check_val("rst_hi", result_hi, 0);
      check_val("rst_flags", {busy, alu_done, ovf, err}, 0);
      @(negedge clk);
      rst = 1'b1;

      run_op("add_100_50", 4'd0, 100, 50);
      run_op("mul_m3_7", 4'd2, -3, 7);
      check_hold("mul_m3_7");
      run_op("mul_m128_m128", 4'd2, -128, -128);
      run_op("div_100_m7", 4'd3, 100, -7);
      run_op("div_5_0", 4'd3, 5, 0);
      run_op("div_m128_m1", 4'd3, -128, -1);
      run_op("div_m7_2", 4'd3, -7, 2);
      run_op("op_9", 4'd9, 12, 34);
      run_op("sub_m128_1", 4'd1, -128, 1);

      // request during RUN must be ignored
      model(4'd2, 5, 6);
      @(negedge clk);
      drive_req(4'd2, 5, 6);
      @(posedge clk);
      @(negedge clk);
      drop_req();
      lat = 0;
      repeat (2) begin
         @(negedge clk);
         lat++;
      end
      drive_req(4'd0, 1, 1);
      @(negedge clk);
      lat++;
      drop_req();
      wait_done("mul_ignore", lat);
      run_op("add_b2b", 4'd0, 1, 1);

      // reset in the middle of an iterative operation
      @(negedge clk);
`ifdef ALU_DIV_EN
      drive_req(4'd3, 100, 7);
`else
      drive_req(4'd2, 100, 7);
`endif
      @(posedge clk);
      @(negedge clk);
      drop_req();
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check_val("abort_res", {result_hi, result_lo}, 0);
      check_val("abort_flags", {busy, alu_done, ovf, err}, 0);
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (alu_done || busy) seen++;
      end
      check_val("abort_quiet", seen, 0);
      run_op("sub_3_5", 4'd1, 3, 5);

      for (int i = 0; i < 250; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 3)      op = 4'd0;
         else if (sel < 5) op = 4'd1;
         else if (sel < 7) op = 4'd2;
         else if (sel < 9) op = 4'd3;
         else              op = 4'($urandom_range(4, 15));
         a = int'($urandom_range(0, 255)) - 128;
         b = int'($urandom_range(0, 255)) - 128;
         case ($urandom_range(0, 11))
            0: b = 0;
            1: begin a = -128; b = -1; end
            2: a = -128;
            default: ;
         endcase
         run_op("rand", op, a, b);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
